// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: mode encoding, bar palette,
// default 640x480@60 timing and the two fixed colours.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } vga_mode_e;

  // Element 0 is the left-most bar.
  localparam logic [7:0][23:0] BAR_PALETTE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK = 24'h000000;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

endpackage

// File: rtl/vga_timing.sv
// VGA scan counters plus the registered sync/valid/address/frame outputs.
// Raw counters are also exported so the pattern logic can register in the same cycle.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  output logic [ADDR_W-1:0] h_cnt,
  output logic [ADDR_W-1:0] v_cnt,
  output logic              active,
  output logic              at_origin,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [ADDR_W-1:0] h_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam logic [ADDR_W-1:0] H_ACT  = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] HS_BEG = ADDR_W'(H_ACTIVE + H_FP);
  localparam logic [ADDR_W-1:0] HS_END = ADDR_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [ADDR_W-1:0] V_ACT  = ADDR_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] VS_BEG = ADDR_W'(V_ACTIVE + V_FP);
  localparam logic [ADDR_W-1:0] VS_END = ADDR_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic              hs_on, vs_on;
  logic              hsync_p1, vsync_p1, vld_p1, frame_start_p1;
  logic [ADDR_W-1:0] h_addr_p1, v_addr_p1;
  logic [7:0]        frame_cnt_p1;
  logic              first_frame_q;

  always_comb begin
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    hs_on     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_on     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  // Stage p0: scan position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clken) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ADDR_W'(1);
      end else begin
        h_cnt <= h_cnt + ADDR_W'(1);
      end
    end
  end

  // Stage p1: registered outputs; the first frame after reset is frame 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_p1       <= 1'b1;
      vsync_p1       <= 1'b1;
      vld_p1         <= 1'b0;
      h_addr_p1      <= '0;
      v_addr_p1      <= '0;
      frame_start_p1 <= 1'b0;
      frame_cnt_p1   <= '0;
      first_frame_q  <= 1'b1;
    end else if (clken) begin
      hsync_p1       <= ~hs_on;
      vsync_p1       <= ~vs_on;
      vld_p1         <= active;
      h_addr_p1      <= active ? h_cnt : '0;
      v_addr_p1      <= active ? v_cnt : '0;
      frame_start_p1 <= at_origin;
      if (at_origin) begin
        first_frame_q <= 1'b0;
        if (!first_frame_q) frame_cnt_p1 <= frame_cnt_p1 + 8'd1;
      end
    end
  end

  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign valid       = vld_p1;
  assign h_addr      = h_addr_p1;
  assign v_addr      = v_addr_p1;
  assign frame_start = frame_start_p1;
  assign frame_cnt   = frame_cnt_p1;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus four-mode test-pattern generator with a single output register stage.
// Optional macro VGA_PATTERN_SCROLL_EN scrolls bars/checker left by 2 pixels per frame.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int NUM_BARS    = 8,
  parameter int CHECK_SHIFT = 5,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic [1:0]        mode,
  input  logic [23:0]       solid_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [ADDR_W-1:0] h_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam logic [ADDR_W-1:0] BAR_PIX_LAST = ADDR_W'(BAR_W - 1);
  localparam logic [ADDR_W-1:0] BAR_IDX_LAST = ADDR_W'(NUM_BARS - 1);
  localparam logic [ADDR_W-1:0] X_LAST       = ADDR_W'(H_ACTIVE - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] pix;
  } bar_pos_t;

  // Advance the bar position by one pixel; the last bar absorbs any remainder.
  function automatic bar_pos_t bar_step(bar_pos_t s, logic [ADDR_W-1:0] x);
    bar_pos_t n;
    n = s;
    if (x == X_LAST) begin
      n = '0;
    end else if ((s.pix == BAR_PIX_LAST) && (s.idx != BAR_IDX_LAST)) begin
      n.idx = s.idx + ADDR_W'(1);
      n.pix = '0;
    end else begin
      n.pix = s.pix + ADDR_W'(1);
    end
    return n;
  endfunction

  logic [ADDR_W-1:0] h_cnt, v_cnt, eff_x;
  logic              active, at_origin;
  bar_pos_t          line_start, bar_cur, bar_q;
  vga_mode_e         mode_q, mode_cur;
  logic [23:0]       solid_q, solid_cur, rgb_nxt, rgb_p1;
  logic              unused_v;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .ADDR_W   (ADDR_W)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .clken       (clken),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .at_origin   (at_origin),
    .hsync       (hsync),
    .vsync       (vsync),
    .valid       (valid),
    .h_addr      (h_addr),
    .v_addr      (v_addr),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

`ifdef VGA_PATTERN_SCROLL_EN
  localparam logic [ADDR_W:0]   H_ACT_X = (ADDR_W+1)'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] H_LAST  = ADDR_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [ADDR_W-1:0] V_LAST  = ADDR_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  function automatic logic [ADDR_W-1:0] x_wrap_inc(logic [ADDR_W-1:0] x);
    return (x == X_LAST) ? '0 : x + ADDR_W'(1);
  endfunction

  logic [ADDR_W-1:0] scroll_x_q, scroll_x_1, scroll_x_2;
  bar_pos_t          scroll_bar_q, scroll_bar_1, scroll_bar_2;
  logic [ADDR_W:0]   x_sum;
  logic              frame_end;

  // scroll_x_q tracks frame_cnt*2 mod H_ACTIVE, with the matching bar position
  always_comb begin
    x_sum        = {1'b0, h_cnt} + {1'b0, scroll_x_q};
    eff_x        = (x_sum >= H_ACT_X) ? ADDR_W'(x_sum - H_ACT_X) : x_sum[ADDR_W-1:0];
    frame_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    scroll_bar_1 = bar_step(scroll_bar_q, scroll_x_q);
    scroll_x_1   = x_wrap_inc(scroll_x_q);
    scroll_bar_2 = bar_step(scroll_bar_1, scroll_x_1);
    scroll_x_2   = x_wrap_inc(scroll_x_1);
    line_start   = scroll_bar_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll_x_q   <= '0;
      scroll_bar_q <= '0;
    end else if (clken && frame_end) begin
      if (frame_cnt == 8'hFF) begin
        scroll_x_q   <= '0;
        scroll_bar_q <= '0;
      end else begin
        scroll_x_q   <= scroll_x_2;
        scroll_bar_q <= scroll_bar_2;
      end
    end
  end
`else
  always_comb begin
    eff_x      = h_cnt;
    line_start = '0;
  end
`endif

  assign unused_v = ^v_cnt;

  // New configuration takes effect exactly on pixel (0,0), never mid-frame.
  always_comb begin
    mode_cur  = at_origin ? vga_mode_e'(mode) : mode_q;
    solid_cur = at_origin ? solid_rgb : solid_q;
    bar_cur   = (h_cnt == '0) ? line_start : bar_q;
  end

  always_comb begin
    rgb_nxt = RGB_BLACK;
    if (active) begin
      case (mode_cur)
        MODE_BARS:  rgb_nxt = BAR_PALETTE[bar_cur.idx[2:0]];
        MODE_CHECK: rgb_nxt = (eff_x[CHECK_SHIFT] ^ v_cnt[CHECK_SHIFT]) ? RGB_WHITE : RGB_BLACK;
        MODE_GRAD:  rgb_nxt = {h_cnt[9:2], v_cnt[8:1], ~h_cnt[9:2]};
        MODE_SOLID: rgb_nxt = solid_cur;
      endcase
    end
  end

  // Stage p1: colour register, aligned with the timing outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_p1  <= '0;
      mode_q  <= MODE_BARS;
      solid_q <= '0;
      bar_q   <= '0;
    end else if (clken) begin
      rgb_p1  <= rgb_nxt;
      bar_q   <= bar_step(bar_cur, eff_x);
      if (at_origin) begin
        mode_q  <= vga_mode_e'(mode);
        solid_q <= solid_rgb;
      end
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_p1;

endmodule
